// File: rtl/checkpoint_seq_monitor.sv
// Checks a status bus against a programmed ordered code list; sticky pass/fail/timeout flags.
// Latency: checkbits change to step/flag update is 2 + STABLE_CYCLES clocks; no backpressure.
module checkpoint_seq_monitor #(
    parameter int CODE_W         = 16,
    parameter int MAX_STEPS      = 8,
    parameter int STABLE_CYCLES  = 2,
    parameter int TIMEOUT_W      = 28,
    parameter int TIMEOUT_CYCLES = 250000
) (
    input  logic                           clock,
    input  logic                           RSTB,
    input  logic                           prog_we,
    input  logic [$clog2(MAX_STEPS)-1:0]   prog_addr,
    input  logic [CODE_W-1:0]              prog_code,
    input  logic [$clog2(MAX_STEPS):0]     num_steps,
    input  logic                           strict,
    input  logic                           start,
    input  logic                           abort,
    input  logic [CODE_W-1:0]              checkbits,
    output logic                           busy,
    output logic                           pass,
    output logic                           fail,
    output logic                           timeout,
    output logic [$clog2(MAX_STEPS):0]     step_idx,
    output logic [CODE_W-1:0]              last_code,
    output logic [TIMEOUT_W-1:0]           cycles
);

    localparam int AW = $clog2(MAX_STEPS);
    localparam int SW = AW + 1;
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [SW-1:0]        MAX_N    = SW'(MAX_STEPS);
    localparam logic [CW-1:0]        STABLE_N = CW'(STABLE_CYCLES);
    localparam logic [TIMEOUT_W-1:0] TOUT_N   = TIMEOUT_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {ST_IDLE, ST_RUN, ST_PASS, ST_FAIL, ST_TOUT} state_t;

    logic [CODE_W-1:0]    tbl_q [MAX_STEPS];

    logic [CODE_W-1:0]    sync1_q, sync2_q;
    logic [CODE_W-1:0]    run_val_q, run_val_d;
    logic [CW-1:0]        run_cnt_q, run_cnt_d;
    logic [CODE_W-1:0]    settled_q, settled_d;
    logic                 settle_evt;

    state_t               state_q, state_d;
    logic [SW-1:0]        nsteps_q, nsteps_d;
    logic                 strict_q, strict_d;
    logic                 busy_q, busy_d;
    logic                 pass_q, pass_d;
    logic                 fail_q, fail_d;
    logic                 timeout_q, timeout_d;
    logic [SW-1:0]        step_idx_q, step_idx_d;
    logic [CODE_W-1:0]    last_code_q, last_code_d;
    logic [TIMEOUT_W-1:0] cycles_q, cycles_d;

    logic [SW-1:0]        n_eff;
    logic [SW-1:0]        step_inc;
    logic [TIMEOUT_W-1:0] cycles_inc;
    logic [CODE_W-1:0]    exp_cur, exp_prev;
    logic                 is_resettle;

    // Glitch filter: the run length includes the current synced sample, so the
    // settle pulse lines up with the STABLE_CYCLES-th equal sample.
    always_comb begin
        run_val_d = sync2_q;
        if (sync2_q != run_val_q) begin
            run_cnt_d = CW'(1);
        end else if (run_cnt_q == STABLE_N) begin
            run_cnt_d = run_cnt_q;
        end else begin
            run_cnt_d = run_cnt_q + CW'(1);
        end
        settle_evt = (run_cnt_d == STABLE_N) && (sync2_q != settled_q);
        settled_d  = settle_evt ? sync2_q : settled_q;
    end

    always_comb begin
        n_eff       = (num_steps > MAX_N) ? MAX_N : num_steps;
        step_inc    = step_idx_q + SW'(1);
        cycles_inc  = cycles_q + TIMEOUT_W'(1);
        exp_cur     = tbl_q[step_idx_q[AW-1:0]];
        exp_prev    = tbl_q[step_idx_q[AW-1:0] - AW'(1)];
        is_resettle = (step_idx_q != '0) && (sync2_q == exp_prev);

        state_d     = state_q;
        nsteps_d    = nsteps_q;
        strict_d    = strict_q;
        busy_d      = busy_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        timeout_d   = timeout_q;
        step_idx_d  = step_idx_q;
        last_code_d = last_code_q;
        cycles_d    = cycles_q;

        if (abort) begin
            state_d    = ST_IDLE;
            busy_d     = 1'b0;
            pass_d     = 1'b0;
            fail_d     = 1'b0;
            timeout_d  = 1'b0;
            step_idx_d = '0;
        end else if (start && state_q != ST_RUN) begin
            nsteps_d    = n_eff;
            strict_d    = strict;
            fail_d      = 1'b0;
            timeout_d   = 1'b0;
            step_idx_d  = '0;
            last_code_d = '0;
            cycles_d    = '0;
            if (n_eff == '0) begin
                state_d = ST_PASS;
                busy_d  = 1'b0;
                pass_d  = 1'b1;
            end else begin
                state_d = ST_RUN;
                busy_d  = 1'b1;
                pass_d  = 1'b0;
            end
        end else if (state_q == ST_RUN) begin
            cycles_d = cycles_inc;
            if (settle_evt) begin
                last_code_d = sync2_q;
            end
            // A match beats a timeout landing on the same cycle.
            if (settle_evt && sync2_q == exp_cur) begin
                step_idx_d = step_inc;
                if (step_inc == nsteps_q) begin
                    state_d = ST_PASS;
                    busy_d  = 1'b0;
                    pass_d  = 1'b1;
                end
            end else if (cycles_inc >= TOUT_N) begin
                state_d   = ST_TOUT;
                busy_d    = 1'b0;
                timeout_d = 1'b1;
                fail_d    = 1'b1;
            end else if (settle_evt && strict_q && !is_resettle) begin
                state_d = ST_FAIL;
                busy_d  = 1'b0;
                fail_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!RSTB) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            run_val_q   <= '0;
            run_cnt_q   <= '0;
            settled_q   <= '0;
            state_q     <= ST_IDLE;
            nsteps_q    <= '0;
            strict_q    <= 1'b0;
            busy_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
            step_idx_q  <= '0;
            last_code_q <= '0;
            cycles_q    <= '0;
        end else begin
            sync1_q     <= checkbits;
            sync2_q     <= sync1_q;
            run_val_q   <= run_val_d;
            run_cnt_q   <= run_cnt_d;
            settled_q   <= settled_d;
            state_q     <= state_d;
            nsteps_q    <= nsteps_d;
            strict_q    <= strict_d;
            busy_q      <= busy_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            timeout_q   <= timeout_d;
            step_idx_q  <= step_idx_d;
            last_code_q <= last_code_d;
            cycles_q    <= cycles_d;
        end
    end

    // Table survives reset so a restart after a mid-run reset reuses it.
    always_ff @(posedge clock) begin
        if (prog_we && !busy_q) begin
            tbl_q[prog_addr] <= prog_code;
        end
    end

    assign busy      = busy_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign timeout   = timeout_q;
    assign step_idx  = step_idx_q;
    assign last_code = last_code_q;
    assign cycles    = cycles_q;

endmodule

// File: tb/tb_checkpoint_seq_monitor.sv
// Directed bench for checkpoint_seq_monitor: vector table plus hand-written corner sequences.
module tb_checkpoint_seq_monitor;

    logic        clock = 1'b0;
    logic        RSTB;
    logic        prog_we;
    logic [2:0]  prog_addr;
    logic [15:0] prog_code;
    logic [3:0]  num_steps;
    logic        strict;
    logic        start;
    logic        abort;
    logic [15:0] checkbits;
    logic        busy, pass, fail, timeout;
    logic [3:0]  step_idx;
    logic [15:0] last_code;
    logic [27:0] cycles;

    int n_tests = 0;
    int n_fail  = 0;

    checkpoint_seq_monitor #(
        .CODE_W(16), .MAX_STEPS(8), .STABLE_CYCLES(4),
        .TIMEOUT_W(28), .TIMEOUT_CYCLES(1000)
    ) dut (
        .clock(clock), .RSTB(RSTB), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_code(prog_code), .num_steps(num_steps), .strict(strict),
        .start(start), .abort(abort), .checkbits(checkbits), .busy(busy),
        .pass(pass), .fail(fail), .timeout(timeout), .step_idx(step_idx),
        .last_code(last_code), .cycles(cycles)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        do_start;
        logic [3:0]  n;
        logic        strict_i;
        logic [15:0] code;
        int          hold;
        logic        e_busy, e_pass, e_fail, e_tout;
        logic [3:0]  e_step;
        logic [15:0] e_last;
        int          e_cycles;
    } vec_t;

    vec_t vecs[9];

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic eb, input logic ep, input logic ef,
                           input logic et, input logic [3:0] es, input logic [15:0] el);
        chk({tag, ".busy"},    32'(busy),      32'(eb));
        chk({tag, ".pass"},    32'(pass),      32'(ep));
        chk({tag, ".fail"},    32'(fail),      32'(ef));
        chk({tag, ".timeout"}, 32'(timeout),   32'(et));
        chk({tag, ".step"},    32'(step_idx),  32'(es));
        chk({tag, ".last"},    32'(last_code), 32'(el));
    endtask

    task automatic do_start(input logic [3:0] n, input logic s);
        num_steps = n;
        strict    = s;
        start     = 1'b1;
        tick(1);
        start     = 1'b0;
    endtask

    task automatic do_prog(input logic [2:0] a, input logic [15:0] c);
        prog_addr = a;
        prog_code = c;
        prog_we   = 1'b1;
        tick(1);
        prog_we   = 1'b0;
    endtask

    task automatic drive(input logic [15:0] c, input int n);
        checkbits = c;
        tick(n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 4'd3, 1'b1, 16'hAB40, 10, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 16'hAB40, 10};
        vecs[1] = '{1'b0, 4'd3, 1'b1, 16'hAB41, 10, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 16'hAB41, 20};
        vecs[2] = '{1'b0, 4'd3, 1'b1, 16'hAB51, 10, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 16'hAB51, 26};
        vecs[3] = '{1'b1, 4'd3, 1'b1, 16'hAB40, 10, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 16'hAB40, 10};
        vecs[4] = '{1'b0, 4'd3, 1'b1, 16'hAB42, 10, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 16'hAB42, 16};
        vecs[5] = '{1'b1, 4'd3, 1'b0, 16'hAB40, 10, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 16'hAB40, 10};
        vecs[6] = '{1'b0, 4'd3, 1'b0, 16'hAB42, 10, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 16'hAB42, 20};
        vecs[7] = '{1'b0, 4'd3, 1'b0, 16'hAB41, 10, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 16'hAB41, 30};
        vecs[8] = '{1'b0, 4'd3, 1'b0, 16'hAB51, 10, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 16'hAB51, 36};

        RSTB = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_code = '0;
        num_steps = '0; strict = 1'b0; start = 1'b0; abort = 1'b0; checkbits = '0;
        tick(3);
        chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000);
        chk("reset.cycles", 32'(cycles), 32'd0);
        RSTB = 1'b1;

        do_prog(3'd0, 16'hAB40);
        do_prog(3'd1, 16'hAB41);
        do_prog(3'd2, 16'hAB51);
        for (int a = 3; a < 8; a++) do_prog(3'(a), 16'hFFFF);
        tick(10);

        // T1 and T3 from the vector table
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].do_start) do_start(vecs[i].n, vecs[i].strict_i);
            drive(vecs[i].code, vecs[i].hold);
            chk_out($sformatf("vec%0d", i), vecs[i].e_busy, vecs[i].e_pass, vecs[i].e_fail,
                    vecs[i].e_tout, vecs[i].e_step, vecs[i].e_last);
            chk($sformatf("vec%0d.cycles", i), 32'(cycles), 32'(vecs[i].e_cycles));
        end

        // T2: only the first code arrives, timeout at run cycle 1000
        do_start(4'd3, 1'b1);
        drive(16'hAB40, 999);
        chk_out("t2.pre", 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 16'hAB40);
        chk("t2.pre.cycles", 32'(cycles), 32'd999);
        tick(1);
        chk_out("t2.tout", 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 16'hAB40);
        chk("t2.cycles", 32'(cycles), 32'd1000);
        tick(5);
        chk("t2.held.cycles", 32'(cycles), 32'd1000);

        // T4a: a 3-cycle glitch is shorter than the filter, strict run still passes
        drive(16'h0000, 10);
        do_start(4'd3, 1'b1);
        drive(16'hAB40, 10);
        drive(16'hAB99, 3);
        drive(16'hAB41, 10);
        chk_out("t4a.glitch", 1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 16'hAB41);
        drive(16'hAB51, 10);
        chk_out("t4a.pass", 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 16'hAB51);

        // T4b: AB40 -> 0000 -> AB40 re-settle is ignored in lenient mode; then abort
        do_start(4'd3, 1'b0);
        drive(16'hAB40, 10);
        drive(16'h0000, 5);
        drive(16'hAB40, 10);
        chk_out("t4b.resettle", 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 16'hAB40);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("t4b.abort.busy", 32'(busy), 32'd0);
        chk("t4b.abort.step", 32'(step_idx), 32'd0);

        // Code already settled on the bus at start is not matched
        do_start(4'd3, 1'b0);
        tick(10);
        chk("pre.settled.step", 32'(step_idx), 32'd0);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;

        // T5: reset mid-run, then the retained table runs the T1 sequence
        drive(16'h0000, 10);
        do_start(4'd3, 1'b1);
        drive(16'hAB40, 10);
        drive(16'hAB41, 10);
        chk("t5.mid.step", 32'(step_idx), 32'd2);
        RSTB = 1'b0;
        tick(1);
        RSTB = 1'b1;
        chk_out("t5.reset", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000);
        chk("t5.reset.cycles", 32'(cycles), 32'd0);
        tick(10);
        do_start(4'd3, 1'b1);
        drive(16'hAB40, 10);
        drive(16'hAB41, 10);
        drive(16'hAB51, 10);
        chk_out("t5.rerun", 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 16'hAB51);

        // T6a: zero steps passes one cycle after start
        do_start(4'd0, 1'b1);
        chk("t6.n0.pass", 32'(pass), 32'd1);
        chk("t6.n0.busy", 32'(busy), 32'd0);

        // T6b: table write while busy is dropped
        do_start(4'd3, 1'b0);
        chk("t6.busy", 32'(busy), 32'd1);
        do_prog(3'd0, 16'hAB77);
        drive(16'hAB40, 10);
        chk("t6.we_busy.step", 32'(step_idx), 32'd1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;

        // T6c: final match lands exactly on run cycle 1000
        drive(16'h0000, 10);
        do_start(4'd1, 1'b1);
        tick(994);
        drive(16'hAB40, 6);
        chk_out("t6.edge", 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 16'hAB40);
        chk("t6.edge.cycles", 32'(cycles), 32'd1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
